// File: rtl/me_sweep_ctrl.sv
// me_sweep_ctrl: sequences one motion-estimation search (preload, then refresh/sweep per column).
module me_sweep_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int RD_BASE  = 32,
  parameter int WR_BASE  = 0,
  parameter int PRE_LEN  = 20,
  parameter int REF_LEN  = 4,
  parameter int SWP_LEN  = 16,
  parameter int CMP_REF  = 2,
  parameter int STRIDE   = 14,
  parameter int NUM_COLS = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              refresh,
  output logic              broadcast,
  output logic              compare_work,
  output logic              compare_refresh,
  output logic [ADDR_W-1:0] sr_addr_rd,
  output logic [ADDR_W-1:0] sr_addr_wr,
  output logic [7:0]        col_idx
);
  typedef enum logic [2:0] {IDLE, PRELOAD, REFRESH, SWEEP, DONE} state_t;
  localparam logic [ADDR_W-1:0] RD0      = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] WR0      = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] JUMP     = ADDR_W'(STRIDE);
  localparam logic [15:0]       PRE_LAST = 16'(PRE_LEN - 1);
  localparam logic [15:0]       REF_LAST = 16'(REF_LEN - 1);
  localparam logic [15:0]       SWP_LAST = 16'(SWP_LEN - 1);
  localparam logic [15:0]       CW_LEN   = 16'(SWP_LEN - CMP_REF);
  localparam logic [7:0]        COL_LAST = 8'(NUM_COLS - 1);
  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        col_q, col_d;
  logic [ADDR_W-1:0] rd_q, rd_d, wr_q, wr_d, step;
  logic              adv;
  logic              busy_q, done_q, mem_q, refresh_q, bcast_q, cw_q, cr_q;
  // next state, counters and addresses; a stall simply leaves everything at its current value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    adv     = 1'b0;
    step    = ADDR_W'(1);
    unique case (state_q)
      IDLE:    state_d = start ? PRELOAD : IDLE;
      PRELOAD: if (!stall) begin
        adv     = 1'b1;
        state_d = (cnt_q == PRE_LAST) ? REFRESH : PRELOAD;
        step    = (cnt_q == PRE_LAST) ? JUMP : ADDR_W'(1);
        cnt_d   = (cnt_q == PRE_LAST) ? 16'd0 : cnt_q + 16'd1;
      end
      REFRESH: if (!stall) begin
        adv     = 1'b1;
        state_d = (cnt_q == REF_LAST) ? SWEEP : REFRESH;
        cnt_d   = (cnt_q == REF_LAST) ? 16'd0 : cnt_q + 16'd1;
      end
      SWEEP:   if (!stall) begin
        cnt_d = (cnt_q == SWP_LAST) ? 16'd0 : cnt_q + 16'd1;
        adv   = (cnt_q != SWP_LAST) || (col_q < COL_LAST);
        if (cnt_q == SWP_LAST) begin
          state_d = (col_q < COL_LAST) ? REFRESH : DONE;
          col_d   = (col_q < COL_LAST) ? col_q + 8'd1 : col_q;
          step    = JUMP;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 16'd0;
        col_d   = 8'd0;
        rd_d    = RD0;
        wr_d    = WR0;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      rd_d = rd_q + step;
      wr_d = wr_q + step;
    end
  end
  // state, counters and output flags registered from the next-state decode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      rd_q      <= RD0;
      wr_q      <= WR0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mem_q     <= 1'b0;
      refresh_q <= 1'b0;
      bcast_q   <= 1'b0;
      cw_q      <= 1'b0;
      cr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      busy_q    <= state_d != IDLE;
      done_q    <= state_d == DONE;
      mem_q     <= state_d inside {PRELOAD, REFRESH, SWEEP};
      refresh_q <= state_d == REFRESH;
      bcast_q   <= state_d == SWEEP;
      cw_q      <= (state_d == SWEEP) && (cnt_d < CW_LEN);
      cr_q      <= (state_d == SWEEP) && (cnt_d >= CW_LEN);
    end
  end
  assign busy            = busy_q;
  assign done            = done_q;
  assign mem_rd          = mem_q & ~stall;
  assign mem_wr          = mem_q & ~stall;
  assign refresh         = refresh_q;
  assign broadcast       = bcast_q;
  assign compare_work    = cw_q;
  assign compare_refresh = cr_q;
  assign sr_addr_rd      = rd_q;
  assign sr_addr_wr      = wr_q;
  assign col_idx         = col_q;
endmodule
